shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle controller that drives the single-step barrel shifter: it takes one request (operand, operation, shift amount) and applies the shifter's 1-bit operation repeatedly, once per clock, to realise shift-by-N. It sits between the instruction-decode/FSM layer and the shifter instance. It owns the shifter's `in` and `shift` inputs and captures its output. The handshake is start/busy/done, with a registered result.

## Interface
Parameters:
- `data_width`, default 16: operand and result width.
- `amt_width`, default `$clog2(data_width)` (4): shift-amount width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: request strobe; sampled only in IDLE.
- `op` input 2: operation code.
  - 00 = pass.
  - 01 = LSL (logical shift left), zero fill.
  - 10 = LSR (logical shift right), zero fill.
  - 11 = ASR (arithmetic shift right), MSB replicated.
- `amount` input `amt_width`: number of 1-bit steps.
- `din` input `data_width`: operand.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse; `dout` is valid in that cycle.
- `dout` output `data_width`: result register, held until the next `done`.
- `sh_in` output `data_width`: drives shifter `in`; always equals the internal accumulator `acc`.
- `sh_shift` output 2: drives shifter `shift`; equals the latched op in SHIFT, otherwise 00.
- `sh_out` input `data_width`: shifter `sout1`.
- `abort` input 1: present only with `SHIFT_SEQ_ABORT_EN`.

## Operation
- Registers: `state`, `acc`, `op_q`, `cnt` (`amt_width` bits), `dout`.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On `start`=1: `acc`←`din`, `op_q`←`op`, `cnt`←`amount`.
  - If `op`=00 or `amount`=0, go to DONE with `dout`←`din`.
  - Otherwise go to SHIFT.
- SHIFT:
  - Every edge: `acc`←`sh_out`, `cnt`←`cnt`−1.
  - When `cnt`=1 at the edge: go to DONE with `dout`←`sh_out`.
- DONE: `done`=1 for exactly this cycle. Unconditional return to IDLE.
- `start` in SHIFT or DONE is ignored, with no queuing. `din`, `op` and `amount` may change freely after acceptance.
- Arithmetic is entirely in the external shifter. LSL/LSR shifts of ≥`data_width` steps give 0. ASR converges to all-sign bits.
- Reset values (`reset_n`=0, asynchronous):
  - `state`=IDLE; `acc`, `dout`, `op_q`, `cnt` = 0.
  - `busy`=0, `done`=0, `sh_shift`=00, `sh_in`=0.
- Reset mid-operation: the operation is discarded, no `done` is produced, and `dout` is cleared.

## Timing
- `start` sampled high at edge 0 (IDLE) → `busy` rises after edge 0.
- `done` is high in the cycle after edge N, where N = `amount` (N=0 when `op`=00).
- Total latency from request to `done` is N+1 cycles.
- `busy` falls after edge N+1. The earliest next `start` is accepted at edge N+2.
- `dout` updates at edge N, is valid in the `done` cycle, and holds until the next DONE entry.
- `sh_in`/`sh_shift` are registered-state-derived. The shifter path is combinational, one level per cycle.

## Configuration
- Macro `SHIFT_SEQ_ABORT_EN`.
- Defined:
  - Adds the `abort` input.
  - `abort`=1 in SHIFT or DONE → IDLE at the next edge. `done` is suppressed (forced 0 in that DONE cycle), and `dout` is unchanged if it was not yet written.
  - `abort`=1 in IDLE blocks acceptance of `start`.
- Undefined: no `abort` port; behaviour exactly as above.

## Test plan
- `din`=16'hF0CF, `op`=01, `amount`=1 → `done` in cycle 2, `dout`=16'hE19E, `sh_shift`=01 for one cycle.
- `din`=16'hF0CF, `op`=10, `amount`=4 → `done` in cycle 5, `dout`=16'h0F0C. Then `op`=11, `amount`=4 → `dout`=16'hFF0C.
- `op`=00, `amount`=9, `din`=16'hF0CF → `done` in cycle 1, `dout`=16'hF0CF. Then `op`=01, `amount`=0 → same result; `sh_shift` stays 00 throughout.
- `op`=01, `amount`=15, `din`=16'hF0CF → `done` in cycle 16, `dout`=16'h8000. Pulse `start` with `din`=16'h0001 during SHIFT → ignored, result unchanged.
- Assert `reset_n`=0 mid-SHIFT (`op`=10, `amount`=8) → `busy`=0, `dout`=0 immediately, no `done`. The next request after release completes normally.
- With `SHIFT_SEQ_ABORT_EN`: `op`=11, `amount`=6, `abort` in cycle 3 → IDLE next edge, no `done`, previous `dout` retained.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer
//
// Multi-cycle controller around an external single-step barrel shifter.
// One request (operand, operation, step count) is accepted in IDLE; the
// shifter's 1-bit operation is then applied once per clock until the step
// count is exhausted, and the final value is registered on dout together
// with a one-cycle done pulse.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the abort input.
// With it, abort in SHIFT/DONE returns to IDLE at the next edge and
// suppresses done; abort in IDLE blocks acceptance of start.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   request strobe, sampled only in IDLE
//   op        in   00 pass, 01 LSL, 10 LSR, 11 ASR
//   amount    in   number of 1-bit steps
//   din       in   operand
//   busy      out  high whenever not IDLE
//   done      out  one-cycle pulse, dout valid in that cycle
//   dout      out  result register, held until the next done
//   sh_in     out  shifter operand (the accumulator)
//   sh_shift  out  shifter operation (latched op in SHIFT, else 00)
//   sh_out    in   shifter single-step result
//   abort     in   only with SHIFT_SEQ_ABORT_EN

module shift_sequencer #(
  parameter int data_width = 16,
  parameter int amt_width  = $clog2(data_width)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [amt_width-1:0]  amount,
  input  logic [data_width-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] dout,
  output logic [data_width-1:0] sh_in,
  output logic [1:0]            sh_shift,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [data_width-1:0] sh_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [data_width-1:0]  acc;
  logic [1:0]             op_q;
  logic [amt_width-1:0]   cnt;

  logic                   abort_req;
  logic                   accept;
  logic                   immediate;
  logic                   last_step;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Pass or zero-step requests bypass SHIFT and complete from din directly.
  assign accept    = (state == IDLE) && start && !abort_req;
  assign immediate = (op == 2'b00) || (amount == '0);
  assign last_step = (cnt == amt_width'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = immediate ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (abort_req) begin
          state_next = IDLE;
        end else if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. An aborted SHIFT step is frozen so dout keeps the
  // previous result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      op_q <= '0;
      cnt  <= '0;
      dout <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc  <= din;
            op_q <= op;
            cnt  <= amount;
            if (immediate) begin
              dout <= din;
            end
          end
        end
        SHIFT: begin
          if (!abort_req) begin
            acc <= sh_out;
            cnt <= cnt - 1'b1;
            if (last_step) begin
              dout <= sh_out;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE) && !abort_req;
    sh_in    = acc;
    sh_shift = (state == SHIFT) ? op_q : 2'b00;
  end

endmodule
